// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell and a carry flip-flop
// process the operands LSB first, one bit per clock, over WIDTH cycles.
module serial_add_sub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic [1:0]       dbg_state
);

  // Handshake: a request is taken on any rising edge where start=1 and busy=0;
  // no ready/ack is returned beyond busy, and requests seen while busy=1 are
  // dropped, not queued. done pulses for one cycle when result/cout/overflow
  // hold the answer, and those outputs stay stable until the next done or reset.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_c_next;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_shifted;

  assign w_s           = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c_next      = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_last        = (r_cnt == LAST);
  assign w_sum_shifted = {w_s, r_sum[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Subtraction rides on the same adder: a + ~b + ~cin == a - b - cin mod 2^WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= cin ^ sub;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_sum   <= w_sum_shifted;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_c_next;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            // r_carry is the carry into the MSB at this point.
            result   <= w_sum_shifted;
            cout     <= w_c_next;
            overflow <= r_carry ^ w_c_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed vectors, exhaustive and
// randomized operations against an arithmetic reference model.
module tb_serial_add_sub;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;
  logic [1:0]   dbg_state;

  int n_checks;
  int n_fail;

  logic [W-1:0]   last_res;
  logic           last_cout;
  logic           last_ovf;
  logic [W+1:0]   exp_q[$];

  serial_add_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic, packed as {cout, overflow, result}.
  function automatic logic [W+1:0] model(input logic s, input logic [W-1:0] x,
                                         input logic [W-1:0] y, input logic ci);
    int ux, uy, uc, sx, sy, uv, sv;
    logic co, ov;
    logic [W-1:0] r;
    ux = int'(x);
    uy = int'(y);
    uc = ci ? 1 : 0;
    sx = x[W-1] ? ux - (1 << W) : ux;
    sy = y[W-1] ? uy - (1 << W) : uy;
    if (!s) begin
      uv = ux + uy + uc;
      sv = sx + sy + uc;
      co = (uv >= (1 << W));
    end else begin
      uv = ux - uy - uc;
      sv = sx - sy - uc;
      co = (ux >= uy + uc);
    end
    ov = (sv > (1 << (W - 1)) - 1) || (sv < -(1 << (W - 1)));
    r  = W'(uv);
    return {co, ov, r};
  endfunction

  // Called just after a falling edge while the DUT is idle.
  task automatic run_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input bit scramble);
    logic [W+1:0] exp;
    int lat;
    exp   = model(s, x, y, ci);
    sub   = s;
    a     = x;
    b     = y;
    cin   = ci;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < 3 * W) begin
      n_checks++;
      if (busy !== 1'b1) begin
        n_fail++;
        $display("FAIL busy_run: busy=%b required 1 (cycle %0d)", busy, lat);
      end
      n_checks++;
      if ({cout, overflow, result} !== {last_cout, last_ovf, last_res}) begin
        n_fail++;
        $display("FAIL hold_run: got %b required %b", {cout, overflow, result},
                 {last_cout, last_ovf, last_res});
      end
      if (scramble) begin
        a     = W'($urandom_range(0, (1 << W) - 1));
        b     = W'($urandom_range(0, (1 << W) - 1));
        cin   = 1'($urandom_range(0, 1));
        sub   = 1'($urandom_range(0, 1));
        start = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== W) begin
      n_fail++;
      $display("FAIL latency: got %0d edges required %0d", lat, W);
    end
    n_checks++;
    if ({cout, overflow, result} !== exp) begin
      n_fail++;
      $display("FAIL result: sub=%b a=%b b=%b cin=%b got {cout,ovf,res}=%b required %b",
               s, x, y, ci, {cout, overflow, result}, exp);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_done: busy=%b required 1", busy);
    end
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after: done=%b busy=%b required 0 0", done, busy);
    end
    {last_cout, last_ovf, last_res} = exp;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, cout, overflow, result} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: {busy,done,cout,ovf,res}=%b required 0",
               {busy, done, cout, overflow, result});
    end
    rst = 1'b0;
    last_res = '0; last_cout = 1'b0; last_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op(1'b0, 4'b0110, 4'b0101, 1'b0, 1'b0);
    run_op(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0);
    run_op(1'b0, 4'b1100, 4'b1011, 1'b1, 1'b0);
    run_op(1'b1, 4'b1001, 4'b0110, 1'b0, 1'b0);
    run_op(1'b1, 4'b0001, 4'b0010, 1'b1, 1'b0);
  endtask

  task automatic test_exhaustive();
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 2; c++)
        for (int x = 0; x < (1 << W); x++)
          for (int y = 0; y < (1 << W); y++)
            run_op(1'(s), W'(x), W'(y), 1'(c), 1'b0);
  endtask

  task automatic test_random_scramble();
    for (int i = 0; i < 150; i++)
      run_op(1'($urandom_range(0, 1)), W'($urandom_range(0, (1 << W) - 1)),
             W'($urandom_range(0, (1 << W) - 1)), 1'($urandom_range(0, 1)), 1'b1);
  endtask

  // start held high: a request is accepted every W+2 cycles, others are dropped.
  task automatic test_back_to_back();
    int n_done;
    logic [W+1:0] exp;
    n_done = 0;
    exp_q.delete();
    for (int k = 0; k < 6 * (W + 2); k++) begin
      n_checks++;
      if (done !== ((k % (W + 2)) == (W + 1))) begin
        n_fail++;
        $display("FAIL b2b_done: cycle %0d done=%b required %b", k, done,
                 ((k % (W + 2)) == (W + 1)));
      end
      if (done === 1'b1) begin
        n_done++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_checks++;
        if ({cout, overflow, result} !== exp) begin
          n_fail++;
          $display("FAIL b2b_result: got %b required %b", {cout, overflow, result}, exp);
        end
      end
      sub   = 1'($urandom_range(0, 1));
      a     = W'($urandom_range(0, (1 << W) - 1));
      b     = W'($urandom_range(0, (1 << W) - 1));
      cin   = 1'($urandom_range(0, 1));
      start = 1'b1;
      if ((k % (W + 2)) == 0) exp_q.push_back(model(sub, a, b, cin));
      @(negedge clk);
    end
    start = 1'b0;
    n_checks++;
    if (n_done !== 6 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: dones=%0d pending=%0d required 6 0", n_done, exp_q.size());
    end
    {last_cout, last_ovf, last_res} = {cout, overflow, result};
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    run_op(1'b0, 4'b0111, 4'b0110, 1'b0, 1'b0);
    sub = 1'b0; a = 4'b0101; b = 4'b0010; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, cout, overflow, result} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: {busy,done,cout,ovf,res}=%b required 0",
               {busy, done, cout, overflow, result});
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold: done=%b busy=%b required 0 0", done, busy);
      end
    end
    last_res = '0; last_cout = 1'b0; last_ovf = 1'b0;
    // rst falls together with start=1; the next edge must take the request.
    rst = 1'b0;
    run_op(1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_exhaustive();
    test_random_scramble();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
